// File: rtl/mac_operand_sequencer_if.sv
// Bundle between the operand feeder and its environment: FIFO push side,
// vector command/status, and the drive lines that wire straight into the MAC.
interface mac_operand_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 8
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_a;
    logic [DATA_WIDTH-1:0] wr_b;
    logic                  full;
    logic                  empty;
    logic                  start;
    logic [LEN_W-1:0]      len;
    logic                  busy;
    logic                  done;
    logic                  Clr;
    logic                  En;
    logic [DATA_WIDTH-1:0] Ain;
    logic [DATA_WIDTH-1:0] Bin;

    modport master (
        output wr_en, wr_a, wr_b, start, len,
        input  full, empty, busy, done, Clr, En, Ain, Bin
    );

    modport slave (
        input  wr_en, wr_a, wr_b, start, len,
        output full, empty, busy, done, Clr, En, Ain, Bin
    );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Buffers (A,B) pairs in a small FIFO and, on start, clears the MAC then streams
// exactly len pairs into it, stalling while the FIFO is dry; pulses done when Cout is final.
module mac_operand_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int LEN_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mac_operand_sequencer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, FINISH} state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [LEN_W-1:0]      rem;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  clr_q;
    logic                  en_q;
    logic                  done_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] ain_q;
    logic [DATA_WIDTH-1:0] bin_q;

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign push       = bus.wr_en && !fifo_full;

    // NOTE: defaults are assigned before the case so every path drives every signal and no latch is inferred.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE:   if (bus.start) next_state = CLEAR;
            CLEAR:  next_state = (rem == '0) ? FINISH : STREAM;
            STREAM: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (rem == REM_ONE) next_state = FINISH;
                end
            end
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            clr_q  <= 1'b0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            ain_q  <= '0;
            bin_q  <= '0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != IDLE);
            clr_q  <= (state == CLEAR);
            en_q   <= pop;
            done_q <= (state == FINISH);
            if (state == IDLE && bus.start) begin
                rem <= bus.len;
            end else if (pop) begin
                rem <= rem - REM_ONE;
            end
            // Operands keep their last value while En is low.
            if (pop) begin
                ain_q <= mem_a[rd_ptr];
                bin_q <= mem_b[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.wr_a;
            mem_b[wr_ptr] <= bus.wr_b;
        end
    end

    assign bus.full  = fifo_full;
    assign bus.empty = fifo_empty;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.Clr   = clr_q;
    assign bus.En    = en_q;
    assign bus.Ain   = ain_q;
    assign bus.Bin   = bin_q;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed plus randomized bench for mac_operand_sequencer: a queue-based reference
// model predicts every output each cycle, and a MAC model checks the dot products.
module tb_mac_operand_sequencer;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int LEN_W      = 8;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_operand_sequencer_if #(.DATA_WIDTH(DATA_WIDTH), .LEN_W(LEN_W)) bus ();

    mac_operand_sequencer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .LEN_W     (LEN_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream MAC: clear on Clr, accumulate Ain*Bin on En.
    logic [31:0] mac_cout;
    always @(posedge clk) begin
        if (bus.Clr === 1'b1)     mac_cout <= 32'd0;
        else if (bus.En === 1'b1) mac_cout <= mac_cout + 32'(bus.Ain) * 32'(bus.Bin);
    end

    // Reference model: FIFO as a queue, vector progress as phase/remaining count.
    pair_t       m_q[$];
    pair_t       m_head;
    int          m_phase = 0;   // 0 idle, 1 clear, 2 stream, 3 finish
    int          m_rem   = 0;
    int          m_occ   = 0;
    logic [31:0] m_sum   = 32'd0;
    logic        m_en    = 1'b0;
    logic        m_clr   = 1'b0;
    logic        m_done  = 1'b0;
    logic [7:0]  m_ain   = 8'd0;
    logic [7:0]  m_bin   = 8'd0;

    task automatic model_step();
        if (!rst_n) begin
            m_q.delete();
            m_phase = 0; m_rem = 0;
            m_en = 1'b0; m_clr = 1'b0; m_done = 1'b0;
            m_ain = 8'd0; m_bin = 8'd0;
        end else begin
            m_occ  = m_q.size();
            m_en   = 1'b0;
            m_clr  = 1'b0;
            m_done = 1'b0;
            case (m_phase)
                0: if (bus.start === 1'b1) begin
                    m_rem = int'(bus.len); m_sum = 32'd0; m_phase = 1;
                end
                1: begin
                    m_clr = 1'b1;
                    m_phase = (m_rem == 0) ? 3 : 2;
                end
                2: if (m_occ > 0) begin
                    m_head = m_q.pop_front();
                    m_ain  = m_head.a;
                    m_bin  = m_head.b;
                    m_en   = 1'b1;
                    m_sum  = m_sum + 32'(m_head.a) * 32'(m_head.b);
                    m_rem--;
                    if (m_rem == 0) m_phase = 3;
                end
                default: begin
                    m_done = 1'b1; m_phase = 0;
                end
            endcase
            if (bus.wr_en === 1'b1 && m_occ < DEPTH) m_q.push_back({bus.wr_a, bus.wr_b});
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Compare process: every output, every cycle, against the model.
    int          en_seen   = 0;
    int          clr_seen  = 0;
    int          done_seen = 0;
    logic [31:0] last_cout = 32'd0;

    initial forever begin
        @(negedge clk);
        check("en",    bus.En,    m_en);
        check("clr",   bus.Clr,   m_clr);
        check("done",  bus.done,  m_done);
        check("busy",  bus.busy,  m_phase != 0);
        check("full",  bus.full,  m_q.size() == DEPTH);
        check("empty", bus.empty, m_q.size() == 0);
        check("ain",   bus.Ain,   m_ain);
        check("bin",   bus.Bin,   m_bin);
        if (m_done) check("cout_at_done", mac_cout, m_sum);
        if (bus.En === 1'b1)   en_seen++;
        if (bus.Clr === 1'b1)  clr_seen++;
        if (bus.done === 1'b1) begin
            done_seen++;
            last_cout = mac_cout;
        end
    end

    int en_base, clr_base, done_base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        bus.wr_en = 1'b1; bus.wr_a = a; bus.wr_b = b;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic mark();
        en_base = en_seen; clr_base = clr_seen; done_base = done_seen;
    endtask

    task automatic start_vec(input int n);
        bus.start = 1'b1; bus.len = LEN_W'(n);
        mark();
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (done_seen == done_base && k < budget) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check({name, "_done_pulses"}, done_seen - done_base, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        bus.wr_en = 1'b0; bus.wr_a = '0; bus.wr_b = '0; bus.start = 1'b0; bus.len = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Reset with the FIFO half full
        for (int i = 0; i < 4; i++) push(8'(i + 1), 8'(i + 2));
        check("half_full_not_empty", bus.empty, 0);
        rst_n = 1'b0;
        #1;
        check("rst_en", bus.En, 0);
        check("rst_clr", bus.Clr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        tick();
        rst_n = 1'b1;
        mark();
        repeat (5) tick();
        check("no_en_after_reset", en_seen - en_base, 0);

        // Basic dot product: (2,2) x4
        for (int i = 0; i < 4; i++) push(8'd2, 8'd2);
        start_vec(4);
        wait_done("basic", 40);
        check("basic_cout", last_cout, 16);
        check("basic_en_cycles", en_seen - en_base, 4);
        check("basic_clr_cycles", clr_seen - clr_base, 1);

        // Stall: one pair ready, two more arrive later
        push(8'd3, 8'd5);
        start_vec(3);
        repeat (2) tick();
        push(8'd1, 8'd1);
        push(8'd4, 8'd2);
        wait_done("stall", 40);
        check("stall_cout", last_cout, 24);
        check("stall_en_cycles", en_seen - en_base, 3);

        // Overflow: 10 pushes, only 8 fit
        for (int i = 1; i <= 10; i++) begin
            push(8'(i), 8'(i));
            if (i == 8) check("full_after_8", bus.full, 1);
        end
        check("full_after_10", bus.full, 1);
        start_vec(8);
        wait_done("overflow", 60);
        check("overflow_cout", last_cout, 204);
        check("overflow_en_cycles", en_seen - en_base, 8);
        check("overflow_drained", bus.empty, 1);

        // len = 0
        start_vec(0);
        wait_done("len0", 20);
        check("len0_cout", last_cout, 0);
        check("len0_en_cycles", en_seen - en_base, 0);
        check("len0_clr_cycles", clr_seen - clr_base, 1);

        // start while busy is ignored
        for (int i = 0; i < 3; i++) push(8'd9, 8'd3);
        start_vec(3);
        bus.start = 1'b1; bus.len = LEN_W'(1);
        repeat (2) tick();
        bus.start = 1'b0;
        wait_done("ignored_start", 40);
        check("ignored_start_cout", last_cout, 81);
        check("ignored_start_en_cycles", en_seen - en_base, 3);
        check("ignored_start_idle", bus.busy, 0);

        // New start accepted in the done cycle
        push(8'd2, 8'd3);
        push(8'd4, 8'd5);
        start_vec(1);
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first_done", bus.done, 1);
        bus.start = 1'b1; bus.len = LEN_W'(1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        mark();
        wait_done("b2b", 20);
        check("b2b_cout", last_cout, 20);
        check("b2b_en_cycles", en_seen - en_base, 1);

        // Reset in the middle of streaming
        for (int i = 0; i < 4; i++) push(8'd7, 8'd7);
        start_vec(4);
        k = 0;
        while (bus.En !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("mid_en_active", bus.En, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", bus.En, 0);
        check("mid_rst_clr", bus.Clr, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_empty", bus.empty, 1);
        check("mid_rst_ain", bus.Ain, 0);
        tick();
        rst_n = 1'b1;
        tick();
        push(8'd1, 8'd1);
        push(8'd1, 8'd1);
        start_vec(2);
        wait_done("after_reset", 20);
        check("after_reset_cout", last_cout, 2);

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.wr_en = ($urandom_range(0, 99) < 55);
            bus.wr_a  = 8'($urandom);
            bus.wr_b  = 8'($urandom);
            bus.start = ($urandom_range(0, 9) == 0);
            bus.len   = LEN_W'($urandom_range(0, 12));
            tick();
        end
        bus.start = 1'b0;
        k = 0;
        while (bus.busy === 1'b1 && k < 400) begin
            bus.wr_en = 1'b1;
            bus.wr_a  = 8'($urandom);
            bus.wr_b  = 8'($urandom);
            tick();
            k++;
        end
        bus.wr_en = 1'b0;
        repeat (4) tick();
        check("random_drain_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
